// File: rtl/queen_pkg.sv
// Shared types for the eight-queens solver: board size, coordinates, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package queen_pkg;

  localparam int N = 8;
  localparam logic [6:0] SOL_MAX = 7'd127;

  typedef logic [2:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PLACE,
    ADVANCE,
    BACKTRACK,
    FOUND,
    EXHAUSTED
  } state_t;

endpackage

// File: rtl/queen_safety_check.sv
// Tests one candidate square against one placed queen for column or diagonal attack.
// Latency: purely combinational.
// Backpressure: none; the result is valid whenever the inputs are.
module safety_check
  import queen_pkg::*;
(
  input  coord_t r_ch,
  input  coord_t c_ch,
  input  coord_t r2,
  input  coord_t c2,
  output logic   threat
);

  coord_t dr;
  coord_t dc;

  // Same column, or equal row and column distance, means the queens attack each other.
  always_comb begin
    dr     = (r_ch >= r2) ? (r_ch - r2) : (r2 - r_ch);
    dc     = (c_ch >= c2) ? (c_ch - c2) : (c2 - c_ch);
    threat = (c_ch == c2) || (dr == dc);
  end

endmodule

// File: rtl/queen_solver.sv
// Backtracking eight-queens sequencer; reports each solution in lexicographic order.
// Latency: one queen pair per CHECK cycle; PLACE/ADVANCE/BACKTRACK one cycle each.
// Backpressure: holds in FOUND until next/start; start/next are ignored while busy.
module queen_solver
  import queen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             next,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [3*N-1:0]   queens,
  output logic [6:0]       sol_count
);

  state_t state;
  coord_t col [N];
  coord_t r;
  coord_t c;
  coord_t k;
  logic   threat;

  // Single shared comparator: candidate (r,c) against the queen already placed in row k.
  safety_check u_safety_check (
    .r_ch   (r),
    .c_ch   (c),
    .r2     (k),
    .c2     (col[k]),
    .threat (threat)
  );

  // The board output is the column registers laid out row by row.
  always_comb begin
    queens = '0;
    for (int i = 0; i < N; i++) begin
      queens[3*i +: 3] = col[i];
    end
  end

  // Search FSM; status flags are updated on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      k         <= '0;
      for (int i = 0; i < N; i++) begin
        col[i] <= '0;
      end
      busy      <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      sol_count <= '0;
    end else begin
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (start) begin
            // Fresh search; start takes priority over next in FOUND.
            r         <= '0;
            c         <= '0;
            k         <= '0;
            sol_count <= '0;
            state     <= CHECK;
            busy      <= 1'b1;
            found     <= 1'b0;
            exhausted <= 1'b0;
          end else if ((state == FOUND) && next) begin
            // Treat the reported row-7 queen as a dead end to move past it.
            r     <= coord_t'(N - 1);
            c     <= col[N-1];
            state <= ADVANCE;
            busy  <= 1'b1;
            found <= 1'b0;
          end
        end

        CHECK: begin
          if (k == r) begin
            state <= PLACE;
          end else if (threat) begin
            state <= ADVANCE;
          end else begin
            k <= k + 3'd1;
          end
        end

        PLACE: begin
          col[r] <= c;
          if (r == 3'd7) begin
            if (sol_count != SOL_MAX) begin
              sol_count <= sol_count + 7'd1;
            end
            state <= FOUND;
            found <= 1'b1;
            busy  <= 1'b0;
          end else begin
            r     <= r + 3'd1;
            c     <= '0;
            k     <= '0;
            state <= CHECK;
          end
        end

        ADVANCE: begin
          if (c == 3'd7) begin
            state <= BACKTRACK;
          end else begin
            c     <= c + 3'd1;
            k     <= '0;
            state <= CHECK;
          end
        end

        BACKTRACK: begin
          if (r == 3'd0) begin
            state     <= EXHAUSTED;
            exhausted <= 1'b1;
            busy      <= 1'b0;
          end else begin
            r     <= r - 3'd1;
            c     <= col[r - 3'd1];
            state <= ADVANCE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          found <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_queen_solver.sv
// Scoreboard bench for queen_solver: expected boards come from an in-bench search model.
// Latency: waits are bounded by cycle budgets.
// Backpressure: n/a.
module tb_queen_solver;
  import queen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        next;
  logic        busy;
  logic        found;
  logic        exhausted;
  logic [23:0] queens;
  logic [6:0]  sol_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] board;
    int          cnt;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] model[$];
  int          m_col[8];

  queen_solver dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .next      (next),
    .busy      (busy),
    .found     (found),
    .exhausted (exhausted),
    .queens    (queens),
    .sol_count (sol_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    logic [23:0] b;
    b = {a7[2:0], a6[2:0], a5[2:0], a4[2:0], a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
    return b;
  endfunction

  // Row 0 is the most significant digit of the lexicographic key.
  function automatic logic [23:0] lex_key(input logic [23:0] b);
    logic [23:0] key;
    key = '0;
    for (int i = 0; i < 8; i++) key = (key << 3) | {21'd0, b[3*i +: 3]};
    return key;
  endfunction

  function automatic bit legal(input logic [23:0] b);
    int ci, cj;
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        ci = int'(b[3*i +: 3]);
        cj = int'(b[3*j +: 3]);
        if (ci == cj) return 1'b0;
        if ((cj - ci == j - i) || (ci - cj == j - i)) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic bit m_ok(input int r);
    for (int j = 0; j < r; j++) begin
      if (m_col[j] == m_col[r]) return 1'b0;
      if ((m_col[j] - m_col[r] == j - r) || (m_col[j] - m_col[r] == r - j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Depth-first search over increasing columns yields solutions in lexicographic order.
  task automatic gen_model();
    int          r;
    logic [23:0] b;
    r = 0;
    m_col[0] = 0;
    while (r >= 0) begin
      if (m_col[r] > 7) begin
        r--;
        if (r >= 0) m_col[r]++;
      end else if (m_ok(r)) begin
        if (r == 7) begin
          b = '0;
          for (int i = 0; i < 8; i++) b[3*i +: 3] = m_col[i][2:0];
          model.push_back(b);
          m_col[r]++;
        end else begin
          r++;
          m_col[r] = 0;
        end
      end else begin
        m_col[r]++;
      end
    end
  endtask

  task automatic push_exp(input logic [23:0] b, input int cnt);
    exp_t e;
    e.board = b;
    e.cnt   = cnt;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic s, input logic n);
    start = s;
    next  = n;
    @(negedge clk);
    start = 1'b0;
    next  = 1'b0;
  endtask

  task automatic wait_found(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (!found && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_found"}, {31'd0, found}, 32'd1);
    e = sb.pop_front();
    chk({tag, "_board"}, {8'd0, queens}, {8'd0, e.board});
    chk({tag, "_count"}, {25'd0, sol_count}, e.cnt);
    chk({tag, "_legal"}, {31'd0, legal(queens)}, 32'd1);
  endtask

  initial begin
    logic [23:0] prev_key;
    logic [23:0] first_board;
    int          n;

    rst   = 1'b1;
    start = 1'b0;
    next  = 1'b0;
    gen_model();
    chk("model_count", model.size(), 32'd92);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_busy",      {31'd0, busy},      32'd0);
    chk("reset_found",     {31'd0, found},     32'd0);
    chk("reset_exhausted", {31'd0, exhausted}, 32'd0);
    chk("reset_queens",    {8'd0, queens},     32'd0);
    chk("reset_count",     {25'd0, sol_count}, 32'd0);

    // First solution, with start/next pulsed while busy to show they are ignored.
    push_exp(model[0], 1);
    pulse(1'b1, 1'b0);
    chk("busy_after_start",  {31'd0, busy},  32'd1);
    chk("found_after_start", {31'd0, found}, 32'd0);
    @(negedge clk);
    pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    chk("busy_ignores_pulses", {31'd0, busy}, 32'd1);
    wait_found("sol1", 20000);
    first_board = pack8(0, 4, 7, 5, 2, 6, 1, 3);
    chk("sol1_const", {8'd0, queens}, {8'd0, first_board});

    // Outputs hold while no next arrives.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_found",  {31'd0, found},     32'd1);
      chk("hold_queens", {8'd0, queens},     {8'd0, first_board});
      chk("hold_count",  {25'd0, sol_count}, 32'd1);
    end

    prev_key = lex_key(queens);
    for (int i = 1; i < 92; i++) begin
      push_exp(model[i], i + 1);
      pulse(1'b0, 1'b1);
      if (i == 1) begin
        chk("next_found_drop", {31'd0, found}, 32'd0);
        chk("next_busy_rise",  {31'd0, busy},  32'd1);
      end
      wait_found($sformatf("sol%0d", i + 1), 20000);
      if (i == 1) chk("sol2_const", {8'd0, queens}, {8'd0, pack8(0, 5, 7, 2, 6, 3, 1, 4)});
      chk($sformatf("sol%0d_lex_order", i + 1), {31'd0, (lex_key(queens) > prev_key)}, 32'd1);
      prev_key = lex_key(queens);
    end
    chk("last_const", {8'd0, queens}, {8'd0, pack8(7, 3, 0, 2, 5, 1, 6, 4)});

    // Search runs out after the 92nd solution.
    pulse(1'b0, 1'b1);
    n = 0;
    while (!exhausted && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("exhausted_flag",  {31'd0, exhausted}, 32'd1);
    chk("exhausted_count", {25'd0, sol_count}, 32'd92);
    chk("exhausted_found", {31'd0, found},     32'd0);
    chk("exhausted_busy",  {31'd0, busy},      32'd0);
    pulse(1'b0, 1'b1);
    @(negedge clk);
    chk("exhausted_next_ignored", {31'd0, exhausted}, 32'd1);
    chk("exhausted_next_busy",    {31'd0, busy},      32'd0);

    // Restart from EXHAUSTED.
    push_exp(model[0], 1);
    pulse(1'b1, 1'b0);
    wait_found("restart_exhausted", 20000);

    // start and next together in FOUND: start wins.
    push_exp(model[0], 1);
    pulse(1'b1, 1'b1);
    chk("start_next_found_drop", {31'd0, found}, 32'd0);
    wait_found("start_wins", 20000);

    // Reset in the middle of a search.
    pulse(1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("midsearch_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_found",     {31'd0, found},     32'd0);
    chk("rst_exhausted", {31'd0, exhausted}, 32'd0);
    chk("rst_queens",    {8'd0, queens},     32'd0);
    chk("rst_count",     {25'd0, sol_count}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/queen_solver.md
# queen_solver

- Sequential eight-queens backtracking solver.
- Holds one column position per row and tests each candidate square against every already-placed queen, one pair per cycle, through a single shared `safety_check` instance.
- Backtracks on dead ends and reports each complete solution in lexicographic order; `next` resumes the search after each one.
- Sits above `safety_check` as its sequencer; a display or host reads `queens` when `found` is high.

## Interface
- No parameters. Board size N=8 and coordinate width 3 are fixed in `queen_pkg`.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a fresh search from the empty board. Accepted in IDLE, FOUND and EXHAUSTED only.
- `next` in 1: resume the search for the following solution. Accepted in FOUND only.
- `busy` out 1: high in CHECK, PLACE, ADVANCE and BACKTRACK.
- `found` out 1: high while in FOUND.
- `exhausted` out 1: high while in EXHAUSTED, i.e. all solutions have been reported.
- `queens` out 24: packed board; `queens[3i+:3]` is the column of the queen in row i. Valid only while `found` is high.
- `sol_count` out 7: number of solutions found since the last `start`. Saturates at 127; 92 is the expected final value.

## Operation
- Registers:
  - `col[0..7]` (3 bits each)
  - current row `r`, candidate column `c`, compare index `k` (3 bits each)
  - state
  - `sol_count`
- The `safety_check` instance is driven with r_ch=r, c_ch=c, r2=k, c2=col[k], giving a combinational `threat`.
- IDLE: on `start`, set r=c=k=0 and sol_count=0, go to CHECK.
- CHECK, evaluated in this priority order:
  - k==r → PLACE (all earlier rows are clear; row 0 goes straight to PLACE).
  - threat → ADVANCE.
  - otherwise k<=k+1 and stay in CHECK.
- PLACE: col[r]<=c.
  - If r==7: sol_count<=sol_count+1 (saturating), go to FOUND.
  - Otherwise: r<=r+1, c<=0, k<=0, go to CHECK.
- ADVANCE:
  - If c==7 → BACKTRACK.
  - Otherwise: c<=c+1, k<=0, go to CHECK.
- BACKTRACK:
  - If r==0 → EXHAUSTED.
  - Otherwise: r<=r-1, c<=col[r-1], go to ADVANCE.
- FOUND:
  - Hold all registers.
  - `next` → ADVANCE with r=7, c=col[7], which continues the search past the current solution.
  - `start` → restart as from IDLE.
- EXHAUSTED: hold; `start` restarts the search.
- Simultaneous `start` and `next` in FOUND: `start` wins.
- `start` or `next` while busy is ignored, with no side effects.
- `next` in IDLE or EXHAUSTED is ignored.
- `queens` is a direct concatenation of `col[]`. It changes freely during the search.
- Width rules:
  - All 3-bit increments are guarded (c==7 and r==7 are checked before incrementing), so nothing wraps.
  - r-1 is taken only when r!=0.

## Timing
- Reset values:
  - state IDLE
  - r=c=k=0, col[*]=0
  - busy=0, found=0, exhausted=0, queens=0, sol_count=0
- `rst` mid-search returns to IDLE on the next edge, discarding all progress.
- `start` sampled in IDLE → busy=1 on the following cycle; the first CHECK is in that cycle.
- Each CHECK cycle evaluates exactly one queen pair. A candidate in row r costs at most r+1 CHECK cycles.
- PLACE, ADVANCE and BACKTRACK each take exactly one cycle.
- FOUND is entered the cycle after the final PLACE. From then on, `found`, `queens` and the updated `sol_count` are stable until `next`, `start` or `rst`.
- `next` sampled in FOUND → found=0 and busy=1 on the following cycle.
- All outputs are registered or decoded from registered state only. No combinational path runs from `start` or `next` to any output.

## Structure
- `queen_pkg`:
  - `N=8`
  - `typedef logic [2:0] coord_t`
  - `typedef enum` state: IDLE, CHECK, PLACE, ADVANCE, BACKTRACK, FOUND, EXHAUSTED
- Sub-modules: exactly one existing `safety_check` instance, shared across all comparisons. No other sub-modules.
- `col[]` is a plain register array inside `queen_solver`.

## Test plan
- Reset, then idle for 5 cycles → busy=0, found=0, exhausted=0, queens=0, sol_count=0.
- Pulse `start` → found rises with rows 0..7 = 0,4,7,5,2,6,1,3, sol_count=1; outputs then stay stable for 20 cycles with no `next`.
- From the first solution pulse `next` → second solution 0,5,7,2,6,3,1,4, sol_count=2.
- Keep pulsing `next` on every FOUND → exactly 92 found episodes with all boards distinct and each independently verified legal. The last board is 7,3,0,2,5,1,6,4; then exhausted=1 and sol_count=92.
- Robustness:
  - `start` and `next` pulsed while busy → ignored, first solution unchanged.
  - `rst` asserted mid-search → IDLE with all registers zero next cycle.
  - `start` in EXHAUSTED → first solution found again with sol_count=1.
- `start` and `next` asserted in the same cycle while in FOUND → restart; the next solution reported is 0,4,7,5,2,6,1,3 with sol_count=1.
